// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue
// Fetch stage byte queue between instruction memory and decode. Each cycle
// one instruction byte (selected from the returned 64-bit word by the low
// address bits) may be pushed into a circular byte queue. Decode sees a
// window of up to WIN_BYTES bytes starting at the oldest byte and retires
// bytes from the head with de_consume.
//
// Handshake: a byte is offered when fet_valid=1 and is accepted unless
// flush=1 or the queue is full with nothing popped that cycle (then it is
// dropped and fet_overflow latches). Decode retires
// n = min(de_consume, fet_win_cnt) bytes per cycle; stall_pc asks the PC
// logic to stop issuing while in-flight bytes could still overfill the queue.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   mem_data         word fetched LOAD_LATENCY cycles earlier
//   pc_to_fet        byte address of the byte carried in mem_data
//   fet_valid        new byte present this cycle
//   flush            discard all buffered bytes (highest priority)
//   de_consume       bytes decode retires this cycle
//   fet_win          window, byte k at [8k+7:8k], byte 0 = oldest
//   fet_win_cnt      valid bytes in window
//   fet_win_pc       byte address of window byte 0
//   stall_pc         back-pressure to PC logic
//   fet_overflow     sticky: byte arrived while queue was full
//
// Optional feature: define FETCH_BYTE_QUEUE_STATS_EN to add the
// stat_stall_cyc and stat_flush_bytes saturating counters.

`ifndef DATA_W
`define DATA_W 64
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

module fetch_byte_queue #(
  parameter int LOAD_LATENCY = 1,
  parameter int QUEUE_DEPTH  = 16,
  parameter int WIN_BYTES    = 15
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [`DATA_W-1:0]     mem_data,
  input  logic [`ADDR_W-1:0]     pc_to_fet,
  input  logic                   fet_valid,
  input  logic                   flush,
  input  logic [3:0]             de_consume,
  output logic [8*WIN_BYTES-1:0] fet_win,
  output logic [3:0]             fet_win_cnt,
  output logic [`ADDR_W-1:0]     fet_win_pc,
  output logic                   stall_pc,
  output logic                   fet_overflow
`ifdef FETCH_BYTE_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_stall_cyc,
  output logic [31:0]            stat_flush_bytes
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [7:0]    push_byte;
  logic [3:0]    pop_n;
  logic          full;
  logic          push_ok;
  logic          push_drop;
  logic [CW-1:0] count_next;

  // Byte lane inside the 64-bit word is chosen by the low three address bits.
  assign push_byte = mem_data[{pc_to_fet[2:0], 3'b000} +: 8];

  assign fet_win_cnt = (count > CW'(WIN_BYTES)) ? 4'(WIN_BYTES) : 4'(count);
  // Over-requests from decode clamp to what the window actually holds.
  assign pop_n       = (de_consume < fet_win_cnt) ? de_consume : fet_win_cnt;
  assign full        = (count == CW'(QUEUE_DEPTH));
  // A push into a full queue still succeeds when a pop frees a slot.
  assign push_ok     = fet_valid && !flush && (!full || (pop_n != 4'd0));
  assign push_drop   = fet_valid && !flush && full && (pop_n == 4'd0);
  assign count_next  = count + CW'(push_ok) - CW'(pop_n);

  // Threshold leaves room for bytes already in flight from memory.
  assign stall_pc = (count >= CW'(QUEUE_DEPTH - LOAD_LATENCY - 1));

  always_comb begin
    fet_win = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      if (CW'(k) < count) begin
        fet_win[8*k +: 8] = mem[rd_ptr + PW'(k)];
      end
    end
  end

  // Storage carries no reset; lanes beyond count are masked in the window.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      fet_win_pc   <= '0;
      fet_overflow <= 1'b0;
    end else if (flush) begin
      // fet_win_pc is left alone; the next push into the empty queue reloads it.
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      fet_overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_n);
      wr_ptr <= wr_ptr + PW'(push_ok);
      count  <= count_next;
      if (push_ok && (count_next == CW'(1))) begin
        fet_win_pc <= pc_to_fet;
      end else begin
        fet_win_pc <= fet_win_pc + `ADDR_W'(pop_n);
      end
      if (push_drop) begin
        fet_overflow <= 1'b1;
      end
    end
  end

`ifdef FETCH_BYTE_QUEUE_STATS_EN
  logic [32:0] flush_sum;
  assign flush_sum = {1'b0, stat_flush_bytes} + 33'(count);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_stall_cyc   <= '0;
      stat_flush_bytes <= '0;
    end else begin
      if (stall_pc && (stat_stall_cyc != '1)) begin
        stat_stall_cyc <= stat_stall_cyc + 32'd1;
      end
      if (flush) begin
        stat_flush_bytes <= flush_sum[32] ? '1 : flush_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Testbench for fetch_byte_queue: directed vectors, a queue-based reference
// model compared every cycle, and hand-computed literal expectations.

`ifndef DATA_W
`define DATA_W 64
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

module tb_fetch_byte_queue;

  logic                 clk;
  logic                 rstn;
  logic [`DATA_W-1:0]   mem_data;
  logic [`ADDR_W-1:0]   pc_to_fet;
  logic                 fet_valid;
  logic                 flush;
  logic [3:0]           de_consume;
  logic [119:0]         fet_win;
  logic [3:0]           fet_win_cnt;
  logic [`ADDR_W-1:0]   fet_win_pc;
  logic                 stall_pc;
  logic                 fet_overflow;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  fetch_byte_queue dut (
    .clk          (clk),
    .rstn         (rstn),
    .mem_data     (mem_data),
    .pc_to_fet    (pc_to_fet),
    .fet_valid    (fet_valid),
    .flush        (flush),
    .de_consume   (de_consume),
    .fet_win      (fet_win),
    .fet_win_cnt  (fet_win_cnt),
    .fet_win_pc   (fet_win_pc),
    .stall_pc     (stall_pc),
    .fet_overflow (fet_overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  logic [31:0] mpc;
  bit          movf;

  always @(posedge clk or negedge rstn) begin : model
    int  wc;
    int  n;
    bit  was_full;
    logic [7:0] b;
    if (!rstn) begin
      mq.delete();
      mpc  = '0;
      movf = 1'b0;
    end else if (flush) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      wc = (mq.size() > 15) ? 15 : mq.size();
      n  = (int'(de_consume) < wc) ? int'(de_consume) : wc;
      was_full = (mq.size() == 16);
      repeat (n) void'(mq.pop_front());
      b = 8'(mem_data >> (8 * int'(pc_to_fet[2:0])));
      if (fet_valid && !(was_full && n == 0)) begin
        mq.push_back(b);
        if (mq.size() == 1) mpc = pc_to_fet;
        else                mpc = mpc + 32'(n);
      end else begin
        if (fet_valid) movf = 1'b1;
        mpc = mpc + 32'(n);
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, on the inactive clock edge.
  always @(negedge clk) begin
    logic [119:0] ew;
    if (cmp_en) begin
      ew = '0;
      for (int k = 0; k < 15; k++) begin
        if (k < mq.size()) ew[8*k +: 8] = mq[k];
      end
      chk("model_win", 128'(fet_win), 128'(ew));
      chk("model_cnt", 128'(fet_win_cnt), 128'((mq.size() > 15) ? 15 : mq.size()));
      chk("model_pc", 128'(fet_win_pc), 128'(mpc));
      chk("model_stall", 128'(stall_pc), 128'(mq.size() >= 14));
      chk("model_ovf", 128'(fet_overflow), 128'(movf));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] mk_word(input logic [31:0] pc);
    logic [63:0] w;
    logic [7:0]  base;
    base = 8'(pc * 7);
    for (int j = 0; j < 8; j++) w[8*j +: 8] = base + 8'(j);
    return w;
  endfunction

  // Byte expected at address pc when the word was built by mk_word(pc).
  function automatic logic [7:0] byte_of(input logic [31:0] pc);
    return 8'(pc * 7) + 8'(pc[2:0]);
  endfunction

  task automatic cyc(input bit v, input logic [63:0] d, input logic [31:0] pc,
                     input bit fl, input logic [3:0] c);
    fet_valid  = v;
    mem_data   = d;
    pc_to_fet  = pc;
    flush      = fl;
    de_consume = c;
    @(posedge clk);
    #1;
    fet_valid  = 1'b0;
    flush      = 1'b0;
    de_consume = 4'd0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [3:0] c);
    cyc(1'b1, mk_word(pc), pc, 1'b0, c);
  endtask

  task automatic do_flush();
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; fet_valid = 1'b0; flush = 1'b0; de_consume = 4'd0;
    mem_data = '0; pc_to_fet = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cmp_en = 1'b1;

    // Single push: byte lane 5 of the word.
    cyc(1'b1, 64'h8877665544332211, 32'h1005, 1'b0, 4'd0);
    chk("t2_byte", 128'(fet_win[7:0]), 128'(8'h66));
    chk("t2_cnt", 128'(fet_win_cnt), 128'd1);
    chk("t2_pc", 128'(fet_win_pc), 128'h1005);
    do_flush();

    // Fill from pc 0 with no consumption.
    for (int i = 0; i < 15; i++) begin
      push(32'(i), 4'd0);
      chk("t3_cnt", 128'(fet_win_cnt), 128'(i + 1));
      chk("t3_stall", 128'(stall_pc), 128'((i + 1) >= 14));
    end
    push(32'd15, 4'd0);
    chk("t3_cap", 128'(fet_win_cnt), 128'd15);
    chk("t3_stall_full", 128'(stall_pc), 128'd1);
    chk("t3_no_ovf", 128'(fet_overflow), 128'd0);
    push(32'd16, 4'd0);
    chk("t3_ovf", 128'(fet_overflow), 128'd1);
    push(32'd16, 4'd1);
    chk("t3_full_pop_push_pc", 128'(fet_win_pc), 128'd1);
    chk("t3_full_pop_push_b15", 128'(fet_win[8*14 +: 8]), 128'(byte_of(32'd15)));
    chk("t3_ovf_sticky", 128'(fet_overflow), 128'd1);
    do_flush();
    chk("t3_flush_ovf", 128'(fet_overflow), 128'd0);
    chk("t3_flush_cnt", 128'(fet_win_cnt), 128'd0);

    // Simultaneous push/pop, then a clamped over-request.
    for (int i = 0; i < 10; i++) push(32'h300 + 32'(i), 4'd0);
    push(32'h30a, 4'd3);
    chk("t4_cnt8", 128'(fet_win_cnt), 128'd8);
    chk("t4_pc", 128'(fet_win_pc), 128'h303);
    chk("t4_head", 128'(fet_win[7:0]), 128'(byte_of(32'h303)));
    cyc(1'b0, 64'h0, 32'h0, 1'b0, 4'd12);
    chk("t4_clamp_cnt", 128'(fet_win_cnt), 128'd0);
    chk("t4_clamp_pc", 128'(fet_win_pc), 128'h30b);

    // Flush beats same-cycle push and pop.
    for (int i = 0; i < 12; i++) push(32'h400 + 32'(i), 4'd0);
    cyc(1'b1, mk_word(32'h40c), 32'h40c, 1'b1, 4'd2);
    chk("t5_cnt", 128'(fet_win_cnt), 128'd0);
    chk("t5_pc_hold", 128'(fet_win_pc), 128'h400);
    push(32'h2000, 4'd0);
    chk("t5_reload_pc", 128'(fet_win_pc), 128'h2000);
    chk("t5_reload_cnt", 128'(fet_win_cnt), 128'd1);
    do_flush();

    // Wrap-around with steady push/pop.
    for (int i = 0; i < 3; i++) push(32'h3000 + 32'(i), 4'd0);
    for (int i = 0; i < 40; i++) push(32'h3003 + 32'(i), 4'd1);
    chk("t6_cnt", 128'(fet_win_cnt), 128'd3);
    chk("t6_pc", 128'(fet_win_pc), 128'h3028);
    for (int k = 0; k < 3; k++)
      chk("t6_lane", 128'(fet_win[8*k +: 8]), 128'(byte_of(32'h3028 + 32'(k))));
    chk("t6_no_ovf", 128'(fet_overflow), 128'd0);
    for (int i = 0; i < 13; i++) push(32'h302b + 32'(i), 4'd0);
    chk("t6_full_stall", 128'(stall_pc), 128'd1);
    push(32'h3038, 4'd0);
    chk("t6_ovf", 128'(fet_overflow), 128'd1);
    repeat (3) cyc(1'b0, 64'h0, 32'h0, 1'b0, 4'd0);
    chk("t6_ovf_hold", 128'(fet_overflow), 128'd1);
    do_flush();
    chk("t6_ovf_clr", 128'(fet_overflow), 128'd0);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 14; i++) push(32'h5000 + 32'(i), 4'd0);
    push(32'h500e, 4'd0);
    #3;
    rstn = 1'b0;
    #1;
    chk("t1_cnt", 128'(fet_win_cnt), 128'd0);
    chk("t1_win", 128'(fet_win), 128'd0);
    chk("t1_pc", 128'(fet_win_pc), 128'd0);
    chk("t1_stall", 128'(stall_pc), 128'd0);
    chk("t1_ovf", 128'(fet_overflow), 128'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push(32'h6001, 4'd0);
    chk("t1_after_pc", 128'(fet_win_pc), 128'h6001);
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
